// File: rtl/pll_phase_sweeper.sv
// ECP5 PLL dynamic-phase sweeper: steps the PLL output phase through a full rotation,
// grades each phase from memory-tester counters and parks on the centre of the best window.
module pll_phase_sweeper #(
   parameter int unsigned C_STEPS  = 8,
   parameter int unsigned C_PULSE  = 4,
   parameter int unsigned C_SETTLE = 1024,
   parameter int unsigned C_WINDOW = 1048576
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               inc,
   input  logic               dec,
   input  logic [31:0]        passcount,
   input  logic [31:0]        failcount,
   output logic               phasedir,
   output logic               phasestep,
   output logic               phaseloadreg,
   output logic [7:0]         phase,
   output logic               busy,
   output logic               done,
   output logic               nopass,
   output logic [7:0]         best_phase,
   output logic [8:0]         window_len,
   output logic [C_STEPS-1:0] pass_map
);

   localparam logic [7:0]         LastPhase  = 8'(C_STEPS - 1);
   localparam logic [8:0]         Steps9     = 9'(C_STEPS);
   localparam logic [9:0]         Steps10    = 10'(C_STEPS);
   localparam logic [31:0]        PulseLast  = 32'(C_PULSE - 1);
   localparam logic [31:0]        SettleLast = 32'(C_SETTLE - 1);
   localparam logic [31:0]        WindowLast = 32'(C_WINDOW - 1);
   localparam logic [31:0]        EvalLast   = 32'(2 * C_STEPS - 1);
   localparam logic [C_STEPS-1:0] MapOne     = C_STEPS'(1);

   typedef enum logic [2:0] {
      StIdle, StStepSetup, StStepPulse, StStepGap, StSettle, StMeasure, StEval, StCenter
   } state_t;

   typedef enum logic [1:0] {ModeManual, ModeSweep, ModeCenter} mode_t;

   state_t      state;
   mode_t       mode;
   logic [31:0] cnt;
   logic [8:0]  visits;
   logic [31:0] snap_p;
   logic [31:0] snap_f;
   logic [8:0]  run_q;
   logic [8:0]  blen_q;
   logic [7:0]  bstart_q;
   logic [7:0]  eidx;

   logic [C_STEPS-1:0] map_shift;
   logic               eval_bit;
   logic               better;
   logic [8:0]         eval_run;
   logic [8:0]         eval_len;
   logic [8:0]         half_len;
   logic [8:0]         center_sum;
   logic [9:0]         start_sum;
   logic [7:0]         eval_start;
   logic [7:0]         eval_best;
   logic [7:0]         eidx_next;
   logic [7:0]         phase_inc;
   logic [7:0]         phase_dec;
   logic [31:0]        dp;
   logic [31:0]        df;
   logic               phase_pass;

   assign phaseloadreg = 1'b0;

   always_comb begin
      map_shift = pass_map >> eidx;
      eval_bit  = map_shift[0];
      if (!eval_bit) begin
         eval_run = '0;
      end else if (run_q == Steps9) begin
         eval_run = run_q;
      end else begin
         eval_run = run_q + 9'd1;
      end
      better = eval_run > blen_q;
      // Run start = (i - run + 1) mod C_STEPS, kept non-negative by adding C_STEPS first
      start_sum = {2'b00, eidx} + Steps10 - {1'b0, eval_run} + 10'd1;
      if (start_sum >= Steps10) begin
         start_sum = start_sum - Steps10;
      end
      eval_len   = better ? eval_run : blen_q;
      eval_start = better ? start_sum[7:0] : bstart_q;
      half_len   = (eval_len - 9'd1) >> 1;
      center_sum = {1'b0, eval_start} + half_len;
      if (center_sum >= Steps9) begin
         center_sum = center_sum - Steps9;
      end
      eval_best  = center_sum[7:0];
      eidx_next  = (eidx == LastPhase) ? 8'd0 : eidx + 8'd1;
      phase_inc  = (phase == LastPhase) ? 8'd0 : phase + 8'd1;
      phase_dec  = (phase == 8'd0) ? LastPhase : phase - 8'd1;
      dp         = passcount - snap_p;
      df         = failcount - snap_f;
      phase_pass = (df == 32'd0) && (dp != 32'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= StIdle;
         mode       <= ModeManual;
         cnt        <= '0;
         visits     <= '0;
         snap_p     <= '0;
         snap_f     <= '0;
         run_q      <= '0;
         blen_q     <= '0;
         bstart_q   <= '0;
         eidx       <= '0;
         phasedir   <= 1'b0;
         phasestep  <= 1'b0;
         phase      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         nopass     <= 1'b0;
         best_phase <= '0;
         window_len <= '0;
         pass_map   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            StIdle: begin
               if (start) begin
                  pass_map <= '0;
                  nopass   <= 1'b0;
                  visits   <= '0;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= StSettle;
               end else if (inc ^ dec) begin
                  phasedir <= dec;
                  mode     <= ModeManual;
                  busy     <= 1'b1;
                  state    <= StStepSetup;
               end
            end
            StStepSetup: begin
               cnt       <= '0;
               phasestep <= 1'b1;
               state     <= StStepPulse;
            end
            StStepPulse: begin
               if (cnt == PulseLast) begin
                  cnt       <= '0;
                  phasestep <= 1'b0;
                  phase     <= phasedir ? phase_dec : phase_inc;
                  state     <= StStepGap;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            StStepGap: begin
               if (cnt == PulseLast) begin
                  cnt <= '0;
                  case (mode)
                     ModeManual: begin
                        busy  <= 1'b0;
                        state <= StIdle;
                     end
                     ModeSweep: begin
                        if (visits == Steps9) begin
                           run_q    <= '0;
                           blen_q   <= '0;
                           bstart_q <= '0;
                           eidx     <= '0;
                           state    <= StEval;
                        end else begin
                           state <= StSettle;
                        end
                     end
                     default: state <= StCenter;
                  endcase
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            StSettle: begin
               if (cnt == SettleLast) begin
                  cnt    <= '0;
                  snap_p <= passcount;
                  snap_f <= failcount;
                  state  <= StMeasure;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            StMeasure: begin
               if (cnt == WindowLast) begin
                  cnt <= '0;
                  if (phase_pass) begin
                     pass_map <= pass_map | (MapOne << phase);
                  end
                  visits   <= visits + 9'd1;
                  phasedir <= 1'b0;
                  mode     <= ModeSweep;
                  state    <= StStepSetup;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            StEval: begin
               run_q    <= eval_run;
               blen_q   <= eval_len;
               bstart_q <= eval_start;
               eidx     <= eidx_next;
               if (cnt == EvalLast) begin
                  cnt        <= '0;
                  window_len <= eval_len;
                  if (eval_len == 9'd0) begin
                     nopass <= 1'b1;
                     done   <= 1'b1;
                     busy   <= 1'b0;
                     state  <= StIdle;
                  end else begin
                     best_phase <= eval_best;
                     state      <= StCenter;
                  end
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            StCenter: begin
               if (phase == best_phase) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= StIdle;
               end else begin
                  phasedir <= 1'b0;
                  mode     <= ModeCenter;
                  state    <= StStepSetup;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_pll_phase_sweeper.sv
// Directed bench for pll_phase_sweeper: manual steps, full sweeps with modelled memory-tester
// counters, no-pass sweeps, counter wrap, ignored requests and asynchronous reset mid-pulse.
module tb_pll_phase_sweeper;

   localparam int unsigned C_STEPS  = 8;
   localparam int unsigned C_PULSE  = 2;
   localparam int unsigned C_SETTLE = 4;
   localparam int unsigned C_WINDOW = 16;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic               inc;
   logic               dec;
   logic [31:0]        passcount;
   logic [31:0]        failcount;
   logic               phasedir;
   logic               phasestep;
   logic               phaseloadreg;
   logic [7:0]         phase;
   logic               busy;
   logic               done;
   logic               nopass;
   logic [7:0]         best_phase;
   logic [8:0]         window_len;
   logic [C_STEPS-1:0] pass_map;

   int         n_pass = 0;
   int         n_checks = 0;
   int         pulse_cnt = 0;
   int         base;
   int         busy_c, step_c, dir_c, lat;
   bit         got;
   logic [7:0] fail_mask = 8'h00;
   logic       pass_en = 1'b0;
   logic       pass_load = 1'b0;
   logic [7:0] d_phase, d_best;
   logic [8:0] d_len;
   logic [7:0] d_map;
   logic       d_nopass, d_busy, st_busy;

   pll_phase_sweeper #(
      .C_STEPS (C_STEPS),
      .C_PULSE (C_PULSE),
      .C_SETTLE(C_SETTLE),
      .C_WINDOW(C_WINDOW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .inc         (inc),
      .dec         (dec),
      .passcount   (passcount),
      .failcount   (failcount),
      .phasedir    (phasedir),
      .phasestep   (phasestep),
      .phaseloadreg(phaseloadreg),
      .phase       (phase),
      .busy        (busy),
      .done        (done),
      .nopass      (nopass),
      .best_phase  (best_phase),
      .window_len  (window_len),
      .pass_map    (pass_map)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory-tester model: failures only at phases flagged in fail_mask
   initial begin
      passcount = 32'd0;
      failcount = 32'd0;
      forever begin
         @(negedge clk);
         if (pass_load) passcount = 32'hFFFF_FFF0;
         else if (pass_en) passcount = passcount + 32'd1;
         if (fail_mask[phase[2:0]]) failcount = failcount + 32'd1;
      end
   end

   initial begin
      forever begin
         @(posedge phasestep);
         pulse_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive_req(input logic s, input logic i, input logic d);
      @(negedge clk);
      start = s;
      inc   = i;
      dec   = d;
      @(negedge clk);
      start = 1'b0;
      inc   = 1'b0;
      dec   = 1'b0;
   endtask

   task automatic watch(input int n, output int bc, output int sc, output int dc);
      bc = 0;
      sc = 0;
      dc = 0;
      for (int k = 0; k < n; k++) begin
         if (busy) bc++;
         if (phasestep) sc++;
         if (busy && phasedir) dc++;
         @(negedge clk);
      end
   endtask

   task automatic run_sweep(output bit g, output int cycles);
      drive_req(1'b1, 1'b0, 1'b0);
      st_busy = busy;
      g = 1'b0;
      cycles = 0;
      for (int k = 0; k < 600 && !g; k++) begin
         if (done) begin
            g        = 1'b1;
            d_phase  = phase;
            d_best   = best_phase;
            d_len    = window_len;
            d_map    = pass_map;
            d_nopass = nopass;
            d_busy   = busy;
         end else begin
            @(negedge clk);
            cycles++;
         end
      end
      if (!g) $error("FAIL sweep_timeout: observed no done expected done within 600 cycles");
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      inc   = 1'b0;
      dec   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_phase", 32'(phase), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_step", 32'(phasestep), 32'd0);
      check("rst_loadreg", 32'(phaseloadreg), 32'd0);
      rst_n = 1'b1;
      pass_en = 1'b1;
      @(negedge clk);

      // Case 1: manual steps
      base = pulse_cnt;
      drive_req(1'b0, 1'b1, 1'b0);
      watch(10, busy_c, step_c, dir_c);
      check("inc_busy_cycles", 32'(busy_c), 32'd5);
      check("inc_step_cycles", 32'(step_c), 32'd2);
      check("inc_dir", 32'(dir_c), 32'd0);
      check("inc_phase", 32'(phase), 32'd1);
      check("inc_pulses", 32'(pulse_cnt - base), 32'd1);
      drive_req(1'b0, 1'b0, 1'b1);
      watch(10, busy_c, step_c, dir_c);
      check("dec_phase_1to0", 32'(phase), 32'd0);
      drive_req(1'b0, 1'b0, 1'b1);
      watch(10, busy_c, step_c, dir_c);
      check("dec_phase_wrap", 32'(phase), 32'd7);
      check("dec_dir_held", 32'(dir_c), 32'd5);
      check("dec_step_cycles", 32'(step_c), 32'd2);
      drive_req(1'b0, 1'b1, 1'b0);
      watch(10, busy_c, step_c, dir_c);
      check("inc_phase_wrap", 32'(phase), 32'd0);

      // Case 2: failures at phases 0,1,6,7 from p0=0
      fail_mask = 8'b1100_0011;
      base = pulse_cnt;
      run_sweep(got, lat);
      check("c2_start_busy", 32'(st_busy), 32'd1);
      check("c2_done", 32'(got), 32'd1);
      check("c2_map", 32'(d_map), 32'h3C);
      check("c2_len", 32'(d_len), 32'd4);
      check("c2_best", 32'(d_best), 32'd3);
      check("c2_phase", 32'(d_phase), 32'd3);
      check("c2_nopass", 32'(d_nopass), 32'd0);
      check("c2_busy_at_done", 32'(d_busy), 32'd0);
      check("c2_pulses", 32'(pulse_cnt - base), 32'd11);
      @(negedge clk);
      check("c2_done_one_cycle", 32'(done), 32'd0);

      // Case 3: failures at phases 2..5 from p0=3, best window wraps around
      fail_mask = 8'b0011_1100;
      base = pulse_cnt;
      run_sweep(got, lat);
      check("c3_map", 32'(d_map), 32'hC3);
      check("c3_len", 32'(d_len), 32'd4);
      check("c3_best", 32'(d_best), 32'd7);
      check("c3_phase", 32'(d_phase), 32'd7);
      check("c3_pulses", 32'(pulse_cnt - base), 32'd12);

      // Case 4: every phase fails
      fail_mask = 8'hFF;
      base = pulse_cnt;
      run_sweep(got, lat);
      check("c4_nopass", 32'(d_nopass), 32'd1);
      check("c4_len", 32'(d_len), 32'd0);
      check("c4_map", 32'(d_map), 32'h00);
      check("c4_best_kept", 32'(d_best), 32'd7);
      check("c4_phase_p0", 32'(d_phase), 32'd7);
      check("c4_pulses", 32'(pulse_cnt - base), 32'd8);
      check("c4_latency", 32'(lat), 32'd216);
      // frozen passcount with no failures also fails
      fail_mask = 8'h00;
      pass_en = 1'b0;
      run_sweep(got, lat);
      check("c4b_nopass", 32'(d_nopass), 32'd1);
      check("c4b_map", 32'(d_map), 32'h00);

      // Case 5: passcount wraps through zero during measurement
      pass_en = 1'b1;
      @(negedge clk);
      pass_load = 1'b1;
      repeat (2) @(negedge clk);
      pass_load = 1'b0;
      base = pulse_cnt;
      run_sweep(got, lat);
      check("c5_map", 32'(d_map), 32'hFF);
      check("c5_len", 32'(d_len), 32'd8);
      check("c5_best", 32'(d_best), 32'd3);
      check("c5_phase", 32'(d_phase), 32'd3);
      check("c5_nopass", 32'(d_nopass), 32'd0);
      check("c5_pulses", 32'(pulse_cnt - base), 32'd12);

      // Case 6: requests while busy, inc+dec together, reset mid-pulse
      base = pulse_cnt;
      drive_req(1'b0, 1'b1, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dec   = 1'b1;
      @(negedge clk);
      dec   = 1'b0;
      watch(10, busy_c, step_c, dir_c);
      check("busy_req_busy", 32'(busy_c), 32'd3);
      check("busy_req_phase", 32'(phase), 32'd4);
      check("busy_req_pulses", 32'(pulse_cnt - base), 32'd1);
      base = pulse_cnt;
      drive_req(1'b0, 1'b1, 1'b1);
      watch(8, busy_c, step_c, dir_c);
      check("incdec_busy", 32'(busy_c), 32'd0);
      check("incdec_pulses", 32'(pulse_cnt - base), 32'd0);
      check("incdec_phase", 32'(phase), 32'd4);

      drive_req(1'b0, 1'b0, 1'b1);
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         if (phasestep) got = 1'b1;
         else @(negedge clk);
      end
      check("mid_pulse_reached", 32'(got), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_step", 32'(phasestep), 32'd0);
      check("arst_dir", 32'(phasedir), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_phase", 32'(phase), 32'd0);
      check("arst_map", 32'(pass_map), 32'd0);
      check("arst_len", 32'(window_len), 32'd0);
      check("arst_best", 32'(best_phase), 32'd0);
      check("arst_nopass", 32'(nopass), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      watch(4, busy_c, step_c, dir_c);
      check("post_rst_idle", 32'(busy_c), 32'd0);
      check("post_rst_phase", 32'(phase), 32'd0);
      drive_req(1'b0, 1'b1, 1'b0);
      watch(10, busy_c, step_c, dir_c);
      check("post_rst_inc_busy", 32'(busy_c), 32'd5);
      check("post_rst_inc_phase", 32'(phase), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
